// File: rtl/truth_table_capture.sv
// Captures one {A,B,C,D} -> {out1,out2,out3} sample per handshake into a 16-entry table,
// then checks it against the golden table. Optional TT_SIGNATURE_EN adds an 8-bit table signature.
module truth_table_capture #(
    parameter logic [47:0] EXPECT   = 48'o3270_1140_3220_1360,
    parameter int          LAST_IDX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_idx,
    input  logic [2:0] in_out,
    input  logic       rd_en,
    input  logic [3:0] rd_idx,
    output logic [2:0] rd_data,
    output logic       rd_vld,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] mis_cnt,
    output logic [3:0] first_mis,
    output logic       dup_err,
    output logic [7:0] sig
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] LAST = 4'(LAST_IDX);

    state_t      state, state_nxt;
    logic [2:0]  tbl [16];
    logic [15:0] mask;
    logic [3:0]  ptr;
    logic        mask_full;
    logic        xfer;

    function automatic logic [2:0] golden(input logic [3:0] i);
        return EXPECT[int'(i)*3 +: 3];
    endfunction

    assign mask_full = &mask[LAST_IDX:0];
    // start wins over a transfer presented in the same cycle
    assign xfer      = in_valid && in_ready && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_CAPTURE;
        end else begin
            unique case (state)
                S_CAPTURE: if (mask_full)   state_nxt = S_CHECK;
                S_CHECK:   if (ptr == LAST) state_nxt = S_DONE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_CAPTURE: begin in_ready = 1'b1; busy = 1'b1; end
            S_CHECK:   busy = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
        pass = done && (mis_cnt == 5'd0);
    end

    // Table storage: data only, visibility is governed by mask
    always_ff @(posedge clk) begin
        if (xfer) tbl[in_idx] <= in_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            dup_err   <= 1'b0;
            ptr       <= '0;
            mis_cnt   <= '0;
            first_mis <= '0;
        end else if (start) begin
            mask      <= '0;
            dup_err   <= 1'b0;
            ptr       <= '0;
            mis_cnt   <= '0;
            first_mis <= '0;
        end else begin
            if (xfer) begin
                mask[in_idx] <= 1'b1;
                if (mask[in_idx]) dup_err <= 1'b1;
            end
            if (state == S_CAPTURE) ptr <= '0;
            if (state == S_CHECK) begin
                ptr <= ptr + 4'd1;
                if (tbl[ptr] != golden(ptr)) begin
                    mis_cnt <= mis_cnt + 5'd1;
                    if (mis_cnt == 5'd0) first_mis <= ptr;
                end
            end
        end
    end

    // Read port: registered, returns pre-write contents on a same-cycle collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) rd_data <= mask[rd_idx] ? tbl[rd_idx] : 3'd0;
        end
    end

`ifdef TT_SIGNATURE_EN
    logic [7:0] sig_q;

    function automatic logic [7:0] sig_step(input logic [7:0] s, input logic [2:0] e);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h07 : 8'h00) ^ {5'b0, e};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 sig_q <= '0;
        else if (start)             sig_q <= 8'hFF;
        else if (state == S_CHECK)  sig_q <= sig_step(sig_q, tbl[ptr]);
    end

    assign sig = sig_q;
`else
    assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomised and directed bench for truth_table_capture against a behavioural model.
// Honours TT_SIGNATURE_EN when the design is built with it.
module tb_truth_table_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_idx = '0;
    logic [2:0] in_out = '0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_idx = '0;
    logic       in_ready, rd_vld, busy, done, pass, dup_err;
    logic [2:0] rd_data;
    logic [4:0] mis_cnt;
    logic [3:0] first_mis;
    logic [7:0] sig;

    truth_table_capture dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_out(in_out), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_vld(rd_vld), .busy(busy), .done(done), .pass(pass), .mis_cnt(mis_cnt),
        .first_mis(first_mis), .dup_err(dup_err), .sig(sig)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int gold [16] = '{0, 6, 3, 1, 0, 2, 2, 3, 0, 4, 1, 1, 0, 7, 2, 3};
    bit rnd_rd = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 capturing, 2 checking (countdown), 3 done
    int          m_phase, m_cnt, m_mis, m_first, m_sig, m_rd_data;
    int          m_tab [16];
    logic [15:0] m_mask;
    bit          m_dup, m_rd_vld;

    task automatic m_reset();
        m_phase = 0; m_cnt = 0; m_mis = 0; m_first = 0; m_sig = 0;
        m_mask = '0; m_dup = 0; m_rd_data = 0; m_rd_vld = 0;
    endtask

    task automatic m_finish();
        logic [7:0] s;
        m_mis = 0;
        m_first = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_tab[i] != gold[i]) begin
                if (m_mis == 0) m_first = i;
                m_mis++;
            end
        end
`ifdef TT_SIGNATURE_EN
        s = 8'hFF;
        for (int i = 0; i < 16; i++)
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h07 : 8'h00) ^ 8'(m_tab[i]);
        m_sig = int'(s);
`else
        s = 8'h00;
        m_sig = int'(s);
`endif
    endtask

    task automatic m_step();
        logic [15:0] pre;
        pre = m_mask;
        if (rd_en) m_rd_data = m_mask[rd_idx] ? m_tab[rd_idx] : 0;
        m_rd_vld = rd_en;
        if (start) begin
            m_phase = 1; m_mask = '0; m_dup = 0; m_mis = 0; m_first = 0;
`ifdef TT_SIGNATURE_EN
            m_sig = 255;
`else
            m_sig = 0;
`endif
        end else if (m_phase == 1) begin
            if (&pre) begin m_phase = 2; m_cnt = 16; end
            if (in_valid) begin
                if (m_mask[in_idx]) m_dup = 1;
                m_tab[in_idx] = int'(in_out);
                m_mask[in_idx] = 1'b1;
            end
        end else if (m_phase == 2) begin
            m_cnt--;
            if (m_cnt == 0) begin m_phase = 3; m_finish(); end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", int'(in_ready), int'(m_phase == 1));
            chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
            chk("done", int'(done), int'(m_phase == 3));
            chk("dup_err", int'(dup_err), int'(m_dup));
            chk("rd_vld", int'(rd_vld), int'(m_rd_vld));
            chk("rd_data", int'(rd_data), m_rd_data);
            if (m_phase != 2) begin
                chk("mis_cnt", int'(mis_cnt), m_mis);
                chk("first_mis", int'(first_mis), m_first);
                chk("pass", int'(pass), int'(m_phase == 3 && m_mis == 0));
                chk("sig", int'(sig), m_sig);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rd) begin
            rd_en  = 1'($urandom % 2);
            rd_idx = 4'($urandom % 16);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send1(input int idx, input int val);
        in_valid = 1'b1;
        in_idx   = 4'(idx);
        in_out   = 3'(val);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_all(input int vals [16]);
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_idx   = 4'(k);
            in_out   = 3'(vals[k]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic read_chk(input string name, input int idx, input int exp);
        rd_en  = 1'b1;
        rd_idx = 4'(idx);
        tick();
        rd_en  = 1'b0;
        chk({name, "_vld"}, int'(rd_vld), 1);
        chk(name, int'(rd_data), exp);
    endtask

    int vals [16];
    int perm [16];
    int n, tmp, j, sig1;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sig", int'(sig), 0);
        chk("rst_rd_vld", int'(rd_vld), 0);
        rst_n = 1'b1;
        tick();

        // Golden sweep with latency measurement
        do_start();
        chk("start_in_ready", int'(in_ready), 1);
        send_all(gold);
        wait_done(n);
        chk("latency", n, 17);
        chk("g_pass", int'(pass), 1);
        chk("g_mis", int'(mis_cnt), 0);
        chk("g_dup", int'(dup_err), 0);
        sig1 = int'(sig);

        // Single fault at index 13
        vals = gold;
        vals[13] = 3;
        do_start();
        send_all(vals);
        wait_done(n);
        chk("sf_pass", int'(pass), 0);
        chk("sf_mis", int'(mis_cnt), 1);
        chk("sf_first", int'(first_mis), 13);
        read_chk("sf_rd13", 13, 3);
        tick();
        chk("sf_rd_vld_drop", int'(rd_vld), 0);
        chk("sf_rd_hold", int'(rd_data), 3);

        // Reverse order plus duplicate of index 5
        do_start();
        for (int k = 15; k >= 1; k--) send1(k, gold[k]);
        send1(5, 7);
        send1(0, gold[0]);
        wait_done(n);
        chk("rv_dup", int'(dup_err), 1);
        chk("rv_mis", int'(mis_cnt), 1);
        chk("rv_first", int'(first_mis), 5);
        read_chk("rv_rd5", 5, 7);

        // Double fault at indices 2 and 9
        vals = gold;
        vals[2] = 0;
        vals[9] = 0;
        do_start();
        send_all(vals);
        wait_done(n);
        chk("df_mis", int'(mis_cnt), 2);
        chk("df_first", int'(first_mis), 2);

        // start colliding with a transfer mid-capture
        do_start();
        for (int k = 0; k < 5; k++) send1(k, gold[k]);
        start = 1'b1; in_valid = 1'b1; in_idx = 4'd5; in_out = 3'd6;
        tick();
        start = 1'b0; in_valid = 1'b0;
        chk("col_in_ready", int'(in_ready), 1);
        chk("col_dup", int'(dup_err), 0);
        read_chk("col_rd5", 5, 0);
        read_chk("col_rd0", 0, 0);
        send_all(gold);
        wait_done(n);
        chk("col_pass", int'(pass), 1);

        // Reset pulsed during CHECK
        do_start();
        send_all(vals);
        repeat (5) tick();
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_in_ready", int'(in_ready), 0);
        chk("mr_mis", int'(mis_cnt), 0);
        chk("mr_first", int'(first_mis), 0);
        chk("mr_rd_data", int'(rd_data), 0);
        chk("mr_sig", int'(sig), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        send_all(gold);
        wait_done(n);
        chk("mr_pass", int'(pass), 1);
        chk("sig_repeat", int'(sig), sig1);
`ifdef TT_SIGNATURE_EN
        chk("sig_nonzero", int'(sig != 8'h00), 1);
`endif

        // Randomised runs with gaps, duplicates, faults and background reads
        rnd_rd = 1'b1;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) perm[i] = i;
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom % (i + 1));
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            do_start();
            for (int k = 0; k < 16; k++) begin
                if ($urandom % 4 == 0) begin
                    in_valid = 1'b0;
                    in_idx = 4'($urandom % 16);
                    tick();
                end
                if (k > 0 && $urandom % 8 == 0)
                    send1(perm[int'($urandom % k)], int'($urandom % 8));
                send1(perm[k], ($urandom % 4 == 0) ? int'($urandom % 8) : gold[perm[k]]);
            end
            wait_done(n);
            for (int k = 0; k < 3; k++) send1(int'($urandom % 16), int'($urandom % 8));
        end
        rnd_rd = 1'b0;
        rd_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
